// File: rtl/rd_adder_arbiter_pkg.sv
// Shared constants, id-width derivation and response tag type for the
// round-robin adder arbiter.
package rd_arb_pkg;

    localparam int unsigned NREQ_DEF = 32'd4;
    localparam int unsigned W_DEF    = 32'd32;
    localparam int unsigned IDW_MAX  = 32'd3;

    function automatic int unsigned idw_f(input int unsigned nreq);
        int unsigned r;
        if (nreq <= 32'd2) begin
            r = 32'd1;
        end else begin
            r = $clog2(nreq);
        end
        return r;
    endfunction

    // Sized for the largest supported NREQ; the top uses only the low IDW bits.
    typedef struct packed {
        logic               valid;
        logic [IDW_MAX-1:0] id;
    } tag_t;

endpackage

// File: rtl/rd_adder_arbiter_if.sv
// Requester/response bundle between issue logic (master) and the shared
// adder arbiter (slave).
interface rd_adder_arbiter_if #(
    parameter int unsigned NREQ = rd_arb_pkg::NREQ_DEF,
    parameter int unsigned W    = rd_arb_pkg::W_DEF
);
    localparam int unsigned IDW = rd_arb_pkg::idw_f(NREQ);

    logic              en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              busy;

    modport master (
        output en, req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  en, req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/rd_adder_arbiter_adder.sv
// Kogge-Stone style recursive doubling adder, no carry-in, with LAT
// output register stages.
module rd_adder
    import rd_arb_pkg::*;
#(
    parameter int unsigned W   = W_DEF,
    parameter int unsigned LAT = 32'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);
    localparam int L = $clog2(W);

    logic [W-1:0] g_s [L+1];
    logic [W-1:0] p_s [L+1];
    logic [W:0]   res_d;
    logic [W:0]   res_q [LAT];

    // Prefix generate/propagate; each level doubles the span it covers.
    always_comb begin
        g_s[0] = a_i & b_i;
        p_s[0] = a_i ^ b_i;
        for (int s = 0; s < L; s++) begin
            for (int i = 0; i < int'(W); i++) begin
                if (i >= (1 << s)) begin
                    g_s[s+1][i] = g_s[s][i] | (p_s[s][i] & g_s[s][i-(1<<s)]);
                    p_s[s+1][i] = p_s[s][i] & p_s[s][i-(1<<s)];
                end else begin
                    g_s[s+1][i] = g_s[s][i];
                    p_s[s+1][i] = p_s[s][i];
                end
            end
        end
        res_d = {g_s[L][W-1], p_s[0] ^ {g_s[L][W-2:0], 1'b0}};
    end

    // Result pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(LAT); k++) begin
                res_q[k] <= '0;
            end
        end else begin
            res_q[0] <= res_d;
            for (int k = 1; k < int'(LAT); k++) begin
                res_q[k] <= res_q[k-1];
            end
        end
    end

    assign {cout_o, sum_o} = res_q[LAT-1];

endmodule

// File: rtl/rd_adder_arbiter_rr_grant.sv
// Combinational round-robin picker: scans upward from ptr with wrap and
// returns a one-hot grant plus the encoded winner.
module rr_grant
    import rd_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    localparam int unsigned IDW = idw_f(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  winner_o,
    output logic            found_o
);

    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        int idx;
        gnt_o    = '0;
        winner_o = '0;
        found_o  = 1'b0;
        idx      = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx      = (int'(ptr_i) + k) % int'(NREQ);
            winner_o = req_i[idx] ? IDW'(idx) : winner_o;
            found_o  = found_o | req_i[idx];
        end
        gnt_o[winner_o] = en_i & found_o;
    end

endmodule

// File: rtl/rd_adder_arbiter.sv
// Round-robin arbiter sharing one registered adder among NREQ requesters;
// responses return tagged with the requester id 1+ADD_LAT cycles after grant.
module rd_adder_arbiter
    import rd_arb_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned W       = W_DEF,
    parameter int unsigned ADD_LAT = 32'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    rd_adder_arbiter_if.slave bus
);
    localparam int unsigned IDW   = idw_f(NREQ);
    localparam int          DEPTH = 1 + int'(ADD_LAT);

    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0]  winner_s;
    logic            found_s;
    logic            hs_s;
    logic            busy_s;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    tag_t            tag_q [DEPTH];
    tag_t            tag_d [DEPTH];
    logic [W-1:0]    sum_s;
    logic            cout_s;

    rr_grant #(.NREQ(NREQ)) u_grant (
        .req_i    (bus.req_valid),
        .ptr_i    (ptr_q),
        .en_i     (bus.en),
        .gnt_o    (gnt_s),
        .winner_o (winner_s),
        .found_o  (found_s)
    );

    assign bus.req_ready = gnt_s;

    // Handshake capture: operands, pointer advance and tag entry.
    always_comb begin
        hs_s   = |gnt_s;
        ptr_d  = ptr_q;
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        busy_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            tag_d[k] = '0;
        end
        for (int k = 1; k < DEPTH; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        if (hs_s) begin
            ptr_d          = (winner_s == IDW'(NREQ - 32'd1)) ? '0 : winner_s + 1'b1;
            op_a_d         = bus.req_a[winner_s*W +: W];
            op_b_d         = bus.req_b[winner_s*W +: W];
            tag_d[0].valid = 1'b1;
            tag_d[0].id    = IDW_MAX'(winner_s);
        end else begin
            tag_d[0] = '0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            busy_s = busy_s | tag_q[k].valid;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q  <= ptr_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            for (int k = 0; k < DEPTH; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    rd_adder #(.W(W), .LAT(ADD_LAT)) u_adder (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .sum_o  (sum_s),
        .cout_o (cout_s)
    );

    assign bus.rsp_valid = tag_q[DEPTH-1].valid;
    assign bus.rsp_id    = tag_q[DEPTH-1].id[IDW-1:0];
    assign bus.rsp_sum   = sum_s;
    assign bus.rsp_cout  = cout_s;
    assign bus.busy      = busy_s;

endmodule

// File: doc/rd_adder_arbiter.md
# rd_adder_arbiter

Round-robin arbiter and sequencer sharing one 32-bit recursive doubling adder among NREQ independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one requester per cycle and latches the operands into the adder's input registers. It returns the sum and carry-out on a single tagged response port a fixed number of cycles later. Sits between the integer issue logic and the shared adder datapath; throughput is one add per cycle.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 32: operand width; must match the adder instance
- ADD_LAT, 1: cycles from adder inputs to valid adder sum/cout (registered adder = 1)
- IDW, $clog2(NREQ): requester-id width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  grant enable; when low no new handshakes, in-flight ops still complete
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester grant, one-hot or zero
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- rsp_valid  out  1  response valid, single-cycle pulse per op
- rsp_id  out  IDW  index of requester owning the response
- rsp_sum  out  W  a+b mod 2^W
- rsp_cout  out  1  carry out of bit W-1
- busy  out  1  at least one op in flight

## Operation
- Priority pointer `ptr` (IDW bits): scan starts at `ptr` and wraps upward mod NREQ. The first i with req_valid[i]=1 wins.
- req_ready[i] = en && winner==i. It is combinational from req_valid, en and ptr.
- Requesters must not make req_valid depend on req_ready.
- Handshake on requester i when req_valid[i] && req_ready[i] at a rising edge. On that edge:
  - op_a/op_b registers load req_a/req_b slice i.
  - ptr <= (i+1) mod NREQ.
  - the tag pipeline stage 0 loads {valid=1, id=i}.
- No handshake, including en=0: ptr holds, op registers hold, and tag stage 0 loads valid=0.
- The adder instance is fed from op_a/op_b.
- The tag pipeline has depth 1+ADD_LAT and shifts every cycle with no stall.
- rsp_valid and rsp_id come from the last tag stage. rsp_sum and rsp_cout come straight from the adder outputs.
- There is no response backpressure; the consumer must accept every rsp_valid pulse.
- busy = OR of all tag-stage valid bits.
- Arithmetic: plain unsigned add, no carry-in. The carry out of bit W-1 goes to rsp_cout; the sum wraps mod 2^W.

## Timing
- Reset (async assert, sync deassert from the system) sets:
  - ptr=0
  - all tag stages invalid, ids 0
  - op_a=op_b=0
  - rsp_valid=0, rsp_id=0, busy=0
  - req_ready follows combinationally: all 0 until en=1 and some req_valid=1.
- Latency: handshake in cycle t gives rsp_valid=1 in cycle t+1+ADD_LAT (t+2 by default), with the matching id, sum and cout.
- Back-to-back handshakes produce back-to-back responses in grant order.
- Single requester held valid: granted every cycle. The pointer moving past it does not starve it, because the scan wraps.
- en deasserted mid-stream: grants stop the same cycle. Outstanding responses still emerge; busy falls the cycle after the last rsp_valid.
- Reset asserted with ops in flight: they are discarded, and no rsp_valid appears after reset.
- req_valid changes between edges: only values at the sampling edge count.

## Structure
- Shared package rd_arb_pkg holds:
  - default NREQ and W constants
  - the IDW derivation function
  - the tag struct {valid, id}
- Natural sub-module: rr_grant, a pure combinational round-robin picker.
  - Inputs: req vector, ptr, en.
  - Outputs: one-hot grant and encoded winner index.
- The top holds the op registers, the tag pipeline, ptr, and the RecursiveDoubling adder instance.

## Test plan
- Single op: req0 with a=0x20430003, b=0x0901800C at cycle t, en=1 -> req_ready=0001 in t; rsp_valid at t+2 with rsp_id=0, rsp_sum=0x2944800F, rsp_cout=0.
- Overflow: req1 with a=0xFFFFFFFF, b=0x00000001 -> rsp_id=1, rsp_sum=0x00000000, rsp_cout=1.
- Fairness: all four req_valid held high from reset with distinct operands -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_id follows the same order 2 cycles later, each sum correct.
- Pointer wrap: lone req2 granted, then req1 and req3 both valid -> req3 granted first, then req1.
- en gating: three back-to-back grants, then en=0 -> req_ready=0 immediately; the three responses still arrive; busy clears one cycle after the last.
- Reset mid-op: handshake at t, rst_n low during t+1 -> no rsp_valid ever appears for that op; after release, ptr=0 and req0 is favoured.
